multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised, multi-channel successor to the single-signal dual-edge Moore detector. Each channel synchronises an asynchronous input, runs a four-state Moore FSM that emits one-clock rising and falling tick pulses, qualifies them with a per-block edge mode, and counts qualified events in a saturating counter. It sits between raw board inputs (buttons, switches, external strobes) and control logic that needs clean single-cycle event pulses and event totals.

## Interface
- WIDTH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (0 = sample `sig` directly, 1..3 otherwise).
- COUNT_WIDTH, 8: bits per channel event counter.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sig  in  WIDTH  raw input per channel; asynchronous to clk.
- mode  in  2  edge qualifier for all channels: bit0 = rising enabled, bit1 = falling enabled (00 none, 01 rise, 10 fall, 11 both).
- clear  in  1  synchronous clear of all counters.
- riseTick  out  WIDTH  one-cycle pulse per sampled 0→1 transition (unqualified).
- fallTick  out  WIDTH  one-cycle pulse per sampled 1→0 transition (unqualified).
- edgeTick  out  WIDTH  qualified pulse: (riseTick & mode[0]) | (fallTick & mode[1]).
- anyEdge  out  1  OR of all edgeTick bits.
- level  out  WIDTH  synchronised, debounce-free level (current FSM level bit).
- count  out  WIDTH*COUNT_WIDTH  per-channel saturating event count; channel i at [i*COUNT_WIDTH +: COUNT_WIDTH].

## Operation
- Per channel, `s` = last synchroniser stage (or `sig[i]` if SYNC_STAGES=0).
- FSM states ZERO, RISE, ONE, FALL; transitions on each clk edge:
  - ZERO: s ? RISE : ZERO.
  - RISE: s ? ONE : FALL.
  - ONE: s ? ONE : FALL.
  - FALL: s ? RISE : ZERO.
- Moore outputs (decoded from state only): riseTick=RISE, fallTick=FALL, level=(RISE|ONE).
- Back-to-back sampled toggles yield consecutive alternating ticks (RISE→FALL→RISE); no transition is dropped once sampled.
- Input pulses that begin and end between two clk rising edges are not seen; this is intended.
- Counter: increments by 1 in any cycle where edgeTick[i]=1; holds at all-ones (no wrap). clear has priority over increment in the same cycle; clear does not affect FSMs or ticks.
- mode changes take effect combinationally on edgeTick/anyEdge in the current cycle; FSMs run regardless of mode.

## Timing
- Reset (async assert, released synchronously to the design by the system): sync flops 0, state ZERO, all ticks 0, level 0, anyEdge 0, counts 0.
- If `sig[i]`=1 at reset release, channel i produces one riseTick after SYNC_STAGES+1 edges (treated as a genuine edge).
- Latency: input change setup before edge k → tick high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1 (exactly one cycle).
- Count reflects a tick one cycle after the tick cycle.
- Reset asserted mid-pulse: ticks drop immediately (asynchronous), counts zeroed.
- Counter at 2^COUNT_WIDTH−1 with tick: stays at max; with clear+tick: 0.

## Structure
- Package `edge_pkg`: state typedef (ZERO, RISE, ONE, FALL) and mode constants MODE_NONE/RISE/FALL/BOTH.
- Sub-module `edge_channel` (synchroniser, FSM, counter for one channel); top instantiates WIDTH copies in a generate loop and forms edgeTick, anyEdge.

## Test plan
- Reset, sig=0, mode=11; raise sig[0] once, hold for 9 cycles → riseTick[0] one cycle, SYNC_STAGES+1 edges after the sampled change; count[0]=1; level[0]=1.
- sig[1] toggled 3× on successive clk periods, mode=11 → rise, fall, rise ticks in consecutive cycles; count[1]=3.
- mode=01, toggle sig[2] 0→1→0 → edgeTick only on rise; fallTick still pulses; count[2]=1.
- Glitch on sig[3] of 1 ns between clk edges → no tick, count unchanged.
- COUNT_WIDTH=4, 17 qualified edges on sig[0] → count[0]=15 (saturated); then clear with simultaneous tick → 0.
- Assert reset while ticks active on all channels → all outputs 0 immediately; reset release with sig[0]=1 → single riseTick[0].

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared FSM state type and edge-mode constants for the edge detector
package edge_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        RISE = 2'd1,
        ONE  = 2'd2,
        FALL = 2'd3
    } state_e;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_channel.sv
// edge_channel: one channel of synchroniser, dual-edge Moore FSM and saturating event counter
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sig_i,
    input  logic                   clear_i,
    input  logic                   edge_tick_i,
    output logic                   rise_tick_o,
    output logic                   fall_tick_o,
    output logic                   level_o,
    output logic [COUNT_WIDTH-1:0] count_o
);

    logic                   s;
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = sig_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            // shift the raw input through the synchroniser chain, oldest sample at the top
            always_ff @(posedge clk or posedge reset)
                if (reset) sync_q <= '0;
                else       sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_i);
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= ZERO;
        else       state_q <= state_d;

    // next state: from a low state a 1 is a new rise, from a high state a 0 is a new fall
    always_comb begin
        state_d = (state_q == ZERO || state_q == FALL) ? (s ? RISE : ZERO)
                                                       : (s ? ONE  : FALL);
    end

    // Moore outputs decoded from state only
    always_comb begin
        rise_tick_o = (state_q == RISE);
        fall_tick_o = (state_q == FALL);
        level_o     = (state_q == RISE) || (state_q == ONE);
    end

    // saturating counter; clear wins over a coincident tick
    always_comb begin
        count_d = clear_i                         ? '0
                : (edge_tick_i && count_q != '1)  ? count_q + 1'b1
                :                                   count_q;
    end

    // counter register
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else       count_q <= count_d;

    assign count_o = count_q;

endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: WIDTH independent edge channels with shared edge-mode qualification
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             sig,
    input  logic [1:0]                   mode,
    input  logic                         clear,
    output logic [WIDTH-1:0]             riseTick,
    output logic [WIDTH-1:0]             fallTick,
    output logic [WIDTH-1:0]             edgeTick,
    output logic                         anyEdge,
    output logic [WIDTH-1:0]             level,
    output logic [WIDTH*COUNT_WIDTH-1:0] count
);

    // qualify the raw ticks with the mode bits; mode acts combinationally
    always_comb begin
        edgeTick = (riseTick & {WIDTH{(mode & MODE_RISE) != MODE_NONE}})
                 | (fallTick & {WIDTH{(mode & MODE_FALL) != MODE_NONE}});
        anyEdge  = |edgeTick;
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            edge_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .COUNT_WIDTH (COUNT_WIDTH)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .sig_i       (sig[i]),
                .clear_i     (clear),
                .edge_tick_i (edgeTick[i]),
                .rise_tick_o (riseTick[i]),
                .fall_tick_o (fallTick[i]),
                .level_o     (level[i]),
                .count_o     (count[i*COUNT_WIDTH +: COUNT_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed-vector self-checking bench for multi_edge_detector
module tb_multi_edge_detector;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  sig;
    logic [1:0]    mode;
    logic          clear;
    logic [W-1:0]  riseTick, fallTick, edgeTick, level;
    logic          anyEdge;
    logic [W*CW-1:0] count;

    int tests = 0;
    int fails = 0;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .COUNT_WIDTH(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .sig      (sig),
        .mode     (mode),
        .clear    (clear),
        .riseTick (riseTick),
        .fallTick (fallTick),
        .edgeTick (edgeTick),
        .anyEdge  (anyEdge),
        .level    (level),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count[ch*CW +: CW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        sig   = '0;
        mode  = 2'b11;
        clear = 1'b0;
        step(2);
        chk("rst_rise",  32'(riseTick), 32'h0);
        chk("rst_fall",  32'(fallTick), 32'h0);
        chk("rst_any",   32'(anyEdge),  32'h0);
        chk("rst_level", 32'(level),    32'h0);
        chk("rst_count", 32'(count),    32'h0);
        reset = 1'b0;
        step(2);

        // single rise on channel 0, latency SYNC_STAGES+1 edges from the sampled change
        sig[0] = 1'b1;
        step(2);
        chk("c0_early",  32'(riseTick), 32'h0);
        step(1);
        chk("c0_rise",   32'(riseTick), 32'h1);
        chk("c0_edge",   32'(edgeTick), 32'h1);
        chk("c0_any",    32'(anyEdge),  32'h1);
        chk("c0_lvl",    32'(level),    32'h1);
        step(1);
        chk("c0_rise_off", 32'(riseTick), 32'h0);
        chk("c0_cnt",    cnt(0),        32'd1);
        step(5);
        chk("c0_hold_cnt", cnt(0), 32'd1);
        chk("c0_hold_lvl", 32'(level), 32'h1);

        // three toggles on channel 1 in consecutive periods
        sig[1] = 1'b1; step(1);
        sig[1] = 1'b0; step(1);
        sig[1] = 1'b1; step(1);
        chk("c1_t1_rise", 32'(riseTick), 32'h2);
        chk("c1_t1_fall", 32'(fallTick), 32'h0);
        step(1);
        chk("c1_t2_fall", 32'(fallTick), 32'h2);
        chk("c1_t2_rise", 32'(riseTick), 32'h0);
        step(1);
        chk("c1_t3_rise", 32'(riseTick), 32'h2);
        step(1);
        chk("c1_quiet",   32'(riseTick | fallTick), 32'h0);
        chk("c1_cnt",     cnt(1), 32'd3);
        chk("c1_lvl",     32'(level), 32'h3);

        // rise-only mode on channel 2
        mode   = 2'b01;
        sig[2] = 1'b1;
        step(3);
        chk("c2_rise",  32'(riseTick), 32'h4);
        chk("c2_edge",  32'(edgeTick), 32'h4);
        step(1);
        sig[2] = 1'b0;
        step(3);
        chk("c2_fall",     32'(fallTick), 32'h4);
        chk("c2_fall_edge", 32'(edgeTick), 32'h0);
        chk("c2_fall_any", 32'(anyEdge),  32'h0);
        mode = 2'b10;
        #1;
        chk("c2_mode_comb", 32'(edgeTick), 32'h4);
        mode = 2'b01;
        #1;
        step(1);
        chk("c2_cnt", cnt(2), 32'd1);

        // sub-period glitch on channel 3 is never sampled
        mode = 2'b11;
        #3 sig[3] = 1'b1;
        #1 sig[3] = 1'b0;
        step(6);
        chk("c3_cnt", cnt(3), 32'd0);
        chk("c3_lvl", 32'(level[3]), 32'h0);

        // 16 more qualified edges on channel 0 saturate its counter at 15
        for (int k = 0; k < 16; k++) begin
            sig[0] = ~sig[0];
            step(1);
        end
        step(5);
        chk("c0_sat", cnt(0), 32'd15);
        sig[0] = ~sig[0];
        step(3);
        chk("c0_sat_tick", 32'(edgeTick[0]), 32'h1);
        chk("c0_sat_hold", cnt(0), 32'd15);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("c0_clear", cnt(0), 32'd0);
        chk("c1_clear", cnt(1), 32'd0);
        step(3);

        // ticks on every channel, then reset mid-pulse
        sig = ~sig;
        step(3);
        chk("all_rise", 32'(riseTick), 32'hd);
        chk("all_fall", 32'(fallTick), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rise",  32'(riseTick), 32'h0);
        chk("mid_rst_fall",  32'(fallTick), 32'h0);
        chk("mid_rst_edge",  32'(edgeTick), 32'h0);
        chk("mid_rst_any",   32'(anyEdge),  32'h0);
        chk("mid_rst_level", 32'(level),    32'h0);
        chk("mid_rst_count", 32'(count),    32'h0);
        sig = 4'b0001;
        step(2);
        reset = 1'b0;
        step(2);
        chk("rel_early", 32'(riseTick), 32'h0);
        step(1);
        chk("rel_rise",  32'(riseTick), 32'h1);
        step(1);
        chk("rel_rise_off", 32'(riseTick), 32'h0);
        step(3);
        chk("rel_cnt", cnt(0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
